// File: rtl/frv_dmem_arbiter_if.sv
// One data-memory bus port: request phase (req/gnt) plus response phase (recv/ack).
// The requester side uses the master modport and the memory side uses the slave modport.
interface frv_dmem_arbiter_if;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        recv;
    logic        ack;
    logic        error;
    logic [31:0] rdata;

    modport master (
        output req, wen, strb, addr, wdata, ack,
        input  gnt, recv, error, rdata
    );

    modport slave (
        input  req, wen, strb, addr, wdata, ack,
        output gnt, recv, error, rdata
    );
endinterface

// File: rtl/frv_dmem_arbiter.sv
// Two-master data memory arbiter: round-robin with lock-on-stall request selection and an
// in-order owner FIFO that steers each response back to the master that issued it.
module frv_dmem_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    frv_dmem_arbiter_if.slave     m0,
    frv_dmem_arbiter_if.slave     m1,
    frv_dmem_arbiter_if.master    s,
    output logic                  arb_error
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEPTH    = cnt_t'(OUTSTANDING);
    localparam ptr_t LAST_PTR = ptr_t'(OUTSTANDING - 1);

    logic lock_valid_q, lock_valid_d;
    logic lock_id_q,    lock_id_d;
    logic last_id_q,    last_id_d;
    logic arb_error_q,  arb_error_d;
    ptr_t rd_ptr_q,     rd_ptr_d;
    ptr_t wr_ptr_q,     wr_ptr_d;
    cnt_t count_q,      count_d;
    logic owner_q [OUTSTANDING];

    logic sel_id;
    logic sel_req;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic head_id;
    logic resp_m0;
    logic resp_m1;
    logic pop;
    logic stray;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    // A locked master keeps the bus; otherwise a lone requester wins and a tie goes
    // to whichever master was not granted last.
    always_comb begin
        if (lock_valid_q) begin
            sel_id  = lock_id_q;
            sel_req = lock_id_q ? m1.req : m0.req;
        end else begin
            sel_req = m0.req | m1.req;
            sel_id  = (m0.req && m1.req) ? ~last_id_q : m1.req;
        end
    end

    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == '0);

    always_comb begin
        s.req   = sel_req && !fifo_full;
        s.wen   = 1'b0;
        s.strb  = '0;
        s.addr  = '0;
        s.wdata = '0;
        if (sel_req) begin
            s.wen   = sel_id ? m1.wen   : m0.wen;
            s.strb  = sel_id ? m1.strb  : m0.strb;
            s.addr  = sel_id ? m1.addr  : m0.addr;
            s.wdata = sel_id ? m1.wdata : m0.wdata;
        end
    end

    assign accept = s.req && s.gnt;
    assign m0.gnt = accept && !sel_id;
    assign m1.gnt = accept &&  sel_id;

    // The head entry is stale while the FIFO is empty, so every use is gated by fifo_empty.
    assign head_id = owner_q[rd_ptr_q];
    assign resp_m0 = !fifo_empty && !head_id;
    assign resp_m1 = !fifo_empty &&  head_id;

    always_comb begin
        m0.recv  = s.recv  && resp_m0;
        m0.error = s.error && resp_m0;
        m0.rdata = resp_m0 ? s.rdata : '0;
        m1.recv  = s.recv  && resp_m1;
        m1.error = s.error && resp_m1;
        m1.rdata = resp_m1 ? s.rdata : '0;
    end

    // A response with nothing outstanding is drained so the bus cannot wedge.
    assign s.ack = fifo_empty ? s.recv : (head_id ? m1.ack : m0.ack);
    assign pop   = s.recv && s.ack && !fifo_empty;
    assign stray = s.recv && fifo_empty;

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        last_id_d    = last_id_q;
        arb_error_d  = arb_error_q | stray;
        rd_ptr_d     = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d     = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d      = count_q + cnt_t'(accept) - cnt_t'(pop);
        if (accept) begin
            lock_valid_d = 1'b0;
            last_id_d    = sel_id;
        end else if (s.req) begin
            lock_valid_d = 1'b1;
            lock_id_d    = sel_id;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= 1'b0;
            last_id_q    <= 1'b1;
            arb_error_q  <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            last_id_q    <= last_id_d;
            arb_error_q  <= arb_error_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Owner storage needs no reset: entries are only read between their push and pop.
    always_ff @(posedge g_clk) begin
        if (g_resetn && accept) begin
            owner_q[wr_ptr_q] <= sel_id;
        end
    end

    assign arb_error = arb_error_q;

    a_gnt_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(m0.gnt && m1.gnt));
    a_no_push_full: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(accept && fifo_full));

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Bench for frv_dmem_arbiter: directed scenarios then random traffic, checked against a
// queue-based model of owner order, round-robin and lock rules via decoupled scoreboards.
module tb_frv_dmem_arbiter;
    localparam int OUTST = 2;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic arb_error;

    frv_dmem_arbiter_if m0_if ();
    frv_dmem_arbiter_if m1_if ();
    frv_dmem_arbiter_if s_if ();

    frv_dmem_arbiter #(.OUTSTANDING(OUTST)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .arb_error (arb_error)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        int          cyc;
        int          id;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        int          id;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int   cyc;
        logic sreq;
        logic sack;
        logic aerr;
        int   head;
        logic idle;
    } bus_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc_cnt = 0;

    // Reference model: owners outstanding in grant order, plus arbitration memory.
    int own_q[$];
    int mdl_last = 1;
    bit mdl_lock_v = 0;
    int mdl_lock_id = 0;
    bit mdl_err = 0;
    bit acc0, acc1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    task automatic fail_event(input string name, input string detail);
        n_total++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc_cnt);
    endtask

    task automatic set_m(input int id, input bit req, input bit wen, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            m0_if.req = req; m0_if.wen = wen; m0_if.strb = strb;
            m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.wen = wen; m1_if.strb = strb;
            m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic set_rand_m(input int id, input bit req);
        set_m(id, req, 1'($urandom), 4'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
    endtask

    task automatic set_s(input bit gnt, input bit recv, input bit err, input logic [31:0] rdata);
        s_if.gnt = gnt; s_if.recv = recv; s_if.error = err; s_if.rdata = rdata;
    endtask

    task automatic set_ack(input bit a0, input bit a1);
        m0_if.ack = a0; m1_if.ack = a1;
    endtask

    // Predict this cycle from current inputs, queue expectations, then advance the model.
    task automatic step();
        bit r0, r1, sreq_sel, exp_sreq, accept, exp_sack, pop;
        int sel, head;
        gnt_t g;
        rsp_t r;
        bus_t b;
        r0 = m0_if.req;
        r1 = m1_if.req;
        if (mdl_lock_v) begin
            sel = mdl_lock_id;
            sreq_sel = (sel == 1) ? r1 : r0;
        end else begin
            sreq_sel = r0 | r1;
            sel = (r0 && r1) ? 1 - mdl_last : (r1 ? 1 : 0);
        end
        exp_sreq = sreq_sel && (own_q.size() < OUTST);
        accept = exp_sreq && s_if.gnt;
        if (accept) begin
            g.cyc = cyc_cnt; g.id = sel;
            g.wen   = (sel == 1) ? m1_if.wen   : m0_if.wen;
            g.strb  = (sel == 1) ? m1_if.strb  : m0_if.strb;
            g.addr  = (sel == 1) ? m1_if.addr  : m0_if.addr;
            g.wdata = (sel == 1) ? m1_if.wdata : m0_if.wdata;
            gnt_q.push_back(g);
        end
        head = (own_q.size() > 0) ? own_q[0] : -1;
        if (head >= 0) begin
            exp_sack = (head == 1) ? m1_if.ack : m0_if.ack;
            if (s_if.recv) begin
                r.cyc = cyc_cnt; r.id = head; r.err = s_if.error; r.rdata = s_if.rdata;
                rsp_q.push_back(r);
            end
        end else begin
            exp_sack = s_if.recv;
        end
        b.cyc = cyc_cnt; b.sreq = exp_sreq; b.sack = exp_sack; b.aerr = mdl_err;
        b.head = head; b.idle = !(r0 || r1) && !mdl_lock_v;
        bus_q.push_back(b);
        pop = s_if.recv && exp_sack && (head >= 0);
        @(posedge g_clk);
        if (pop) void'(own_q.pop_front());
        if (s_if.recv && head < 0) mdl_err = 1;
        if (accept) begin
            own_q.push_back(sel);
            mdl_last = sel;
            mdl_lock_v = 0;
        end else if (exp_sreq) begin
            mdl_lock_v = 1;
            mdl_lock_id = sel;
        end
        acc0 = accept && (sel == 0);
        acc1 = accept && (sel == 1);
        cyc_cnt++;
        #1;
    endtask

    task automatic idle_inputs();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 0, 0, 32'h0);
        set_ack(0, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        own_q.delete();
        mdl_last = 1; mdl_lock_v = 0; mdl_lock_id = 0; mdl_err = 0;
        cyc_cnt += 2;
    endtask

    task automatic drain();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_ack(1, 1);
        for (int i = 0; i < OUTST + 2 && own_q.size() > 0; i++) begin
            set_s(0, 1, 1'($urandom), $urandom);
            step();
        end
        set_s(0, 0, 0, 32'h0);
        step();
    endtask

    // Monitor: consume expectations whenever the DUT presents a grant or a response.
    always @(negedge g_clk) begin : mon
        bus_t b;
        gnt_t g;
        rsp_t r;
        if (g_resetn) begin
            if (bus_q.size() > 0) begin
                b = bus_q.pop_front();
                check("s_req", 32'(s_if.req), 32'(b.sreq));
                check("s_ack", 32'(s_if.ack), 32'(b.sack));
                check("arb_error", 32'(arb_error), 32'(b.aerr));
                if (b.head != 0) begin
                    check("m0_recv_idle", 32'(m0_if.recv), 32'd0);
                    check("m0_rdata_idle", m0_if.rdata, 32'd0);
                    check("m0_error_idle", 32'(m0_if.error), 32'd0);
                end
                if (b.head != 1) begin
                    check("m1_recv_idle", 32'(m1_if.recv), 32'd0);
                    check("m1_rdata_idle", m1_if.rdata, 32'd0);
                    check("m1_error_idle", 32'(m1_if.error), 32'd0);
                end
                if (b.idle) begin
                    check("s_addr_idle", s_if.addr, 32'd0);
                    check("s_wdata_idle", s_if.wdata, 32'd0);
                    check("s_fields_idle", {27'd0, s_if.wen, s_if.strb}, 32'd0);
                end
            end
            if (m0_if.gnt || m1_if.gnt) begin
                if (gnt_q.size() == 0) begin
                    fail_event("unexpected_gnt", $sformatf("got m0_gnt=%0b m1_gnt=%0b expected none",
                               m0_if.gnt, m1_if.gnt));
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_pair", {30'd0, m1_if.gnt, m0_if.gnt}, (g.id == 1) ? 32'd2 : 32'd1);
                    check("s_addr", s_if.addr, g.addr);
                    check("s_wdata", s_if.wdata, g.wdata);
                    check("s_wen_strb", {27'd0, s_if.wen, s_if.strb}, {27'd0, g.wen, g.strb});
                end
            end
            if (gnt_q.size() > 0 && gnt_q[0].cyc <= cyc_cnt) begin
                g = gnt_q.pop_front();
                fail_event("missing_gnt", $sformatf("got no grant expected m%0d_gnt=1", g.id));
            end
            if (m0_if.recv || m1_if.recv) begin
                if (rsp_q.size() == 0) begin
                    fail_event("unexpected_recv", $sformatf("got m0_recv=%0b m1_recv=%0b expected none",
                               m0_if.recv, m1_if.recv));
                end else begin
                    r = rsp_q.pop_front();
                    check("recv_pair", {30'd0, m1_if.recv, m0_if.recv}, (r.id == 1) ? 32'd2 : 32'd1);
                    check("rdata", (r.id == 1) ? m1_if.rdata : m0_if.rdata, r.rdata);
                    check("error", 32'((r.id == 1) ? m1_if.error : m0_if.error), 32'(r.err));
                end
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc_cnt) begin
                r = rsp_q.pop_front();
                fail_event("missing_recv", $sformatf("got no response expected m%0d_recv=1", r.id));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle_inputs();
        #1;
        // Single master load and its response.
        do_reset();
        step();
        set_m(0, 1, 0, 4'h0, 32'h100, 32'h0);
        set_s(1, 0, 0, 32'h0);
        step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 1, 0, 32'hDEADBEEF);
        set_ack(1, 0);
        step();
        set_s(0, 0, 0, 32'h0);
        step();

        // Tie with continuous grants and immediate responses.
        do_reset();
        set_ack(1, 1);
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || acc0) set_rand_m(0, 1);
            if (i == 0 || acc1) set_rand_m(1, 1);
            set_s(1, own_q.size() > 0, 0, $urandom);
            step();
        end
        drain();

        // Lock on a stalled m1 while m0 competes.
        do_reset();
        set_m(1, 1, 1, 4'hF, 32'h0000_2000, 32'hCAFE_0001);
        step();
        set_m(0, 1, 0, 4'h0, 32'h0000_1000, 32'h0);
        step();
        step();
        set_s(1, 0, 0, 32'h0);
        step();
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        step();
        drain();

        // FIFO full: a same-cycle pop still blocks the grant.
        do_reset();
        set_s(1, 0, 0, 32'h0);
        set_m(0, 1, 0, 4'h0, 32'h0000_0040, 32'h0);
        step();
        set_m(0, 1, 1, 4'h3, 32'h0000_0044, 32'h1234_5678);
        step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1, 0, 4'h0, 32'h0000_0048, 32'h0);
        step();
        set_ack(1, 1);
        set_s(1, 1, 0, 32'hA5A5_0001);
        step();
        set_s(1, 0, 0, 32'h0);
        step();
        drain();

        // Owners out of master order, with an m1 response stall.
        do_reset();
        set_s(1, 0, 0, 32'h0);
        set_m(1, 1, 0, 4'h0, 32'h0000_0200, 32'h0);
        step();
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(0, 1, 0, 4'h0, 32'h0000_0300, 32'h0);
        step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 1, 0, 32'h11);
        set_ack(1, 0);
        step();
        set_ack(0, 1);
        step();
        set_s(0, 1, 0, 32'h22);
        set_ack(1, 0);
        step();
        set_s(0, 0, 0, 32'h0);
        step();

        // Stray response, then reset with a transaction outstanding.
        do_reset();
        set_s(0, 1, 0, 32'h5555_AAAA);
        step();
        set_s(0, 0, 0, 32'h0);
        step();
        step();
        set_m(0, 1, 0, 4'h0, 32'h0000_0400, 32'h0);
        set_s(1, 0, 0, 32'h0);
        step();
        do_reset();
        step();
        set_s(0, 1, 0, 32'h7777_0000);
        set_ack(1, 1);
        step();
        set_m(0, 1, 0, 4'h0, 32'h0000_0500, 32'h0);
        set_m(1, 1, 0, 4'h0, 32'h0000_0600, 32'h0);
        set_s(1, 0, 0, 32'h0);
        step();
        drain();

        // Random traffic.
        do_reset();
        acc0 = 1; acc1 = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!m0_if.req || acc0) set_rand_m(0, $urandom_range(0, 2) != 0);
            if (!m1_if.req || acc1) set_rand_m(1, $urandom_range(0, 2) != 0);
            set_s($urandom_range(0, 3) != 0, (own_q.size() > 0) && ($urandom_range(0, 1) == 1),
                  1'($urandom), $urandom);
            set_ack($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
        end
        drain();

        @(negedge g_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frv_dmem_arbiter.md
# frv_dmem_arbiter

Two-master arbiter that shares the core's single data memory bus between the LSU port and a secondary requester (e.g. a coprocessor or debug access port). It forwards one master's request onto the shared bus using the req/gnt handshake. It records each accepted transaction's owner in a small in-order FIFO and routes the response phase (recv/ack/error/rdata) back to that owner. It sits between the LSU `dmem_*` port and the memory interconnect.

## Interface
- `OUTSTANDING`, 2: maximum accepted-but-unresponded transactions (FIFO depth, power of two, ≥1).
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  reset g_resetn, synchronous, active-low; clock g_clk.
- `m0_req / m1_req`  in  1  master request. Master 0 is the LSU, master 1 is secondary. Once asserted, a master holds req and all request fields stable until its gnt.
- `m0_wen / m1_wen`  in  1  write enable.
- `m0_strb / m1_strb`  in  4  write byte strobe.
- `m0_addr / m1_addr`  in  32  word-aligned address.
- `m0_wdata / m1_wdata`  in  32  write data.
- `m0_gnt / m1_gnt`  out  1  request accepted.
- `m0_recv / m1_recv`  out  1  response valid to master.
- `m0_ack / m1_ack`  in  1  master accepts response.
- `m0_error / m1_error`  out  1  response error.
- `m0_rdata / m1_rdata`  out  32  response read data.
- `s_req, s_wen, s_strb[3:0], s_addr[31:0], s_wdata[31:0]`  out  shared bus request.
- `s_gnt`  in  1  shared bus accepted request.
- `s_recv, s_error, s_rdata[31:0]`  in  shared bus response.
- `s_ack`  out  1  response accepted.
- `arb_error`  out  1  sticky: a response arrived with no outstanding transaction.

## Operation
- State: `lock_valid`, `lock_id`, `last_id` (last granted master), owner FIFO (`OUTSTANDING` entries of 1 bit, rd/wr pointers, count), `arb_error`.
- Selection:
  - If `lock_valid`, select `lock_id`.
  - Otherwise, if exactly one master requests, select it.
  - If both request, select `!last_id` (round-robin).
- Request forwarding is combinational.
  - `s_req = sel_req && !fifo_full`.
  - `s_wen/strb/addr/wdata` come from the selected master. They are 0 when no master is selected.
- Lock: if `s_req && !s_gnt`, set `lock_valid=1` and `lock_id=sel`. The arbiter never switches masters while a presented request is ungranted. Clear the lock on `s_req && s_gnt`.
- Accept: on `s_req && s_gnt`:
  - `m<sel>_gnt=1` in the same cycle.
  - push `sel` into the FIFO.
  - set `last_id=sel`.
  - The other master's gnt stays 0.
- FIFO full: `s_req=0` and no gnt, even if a pop occurs in the same cycle. Requests remain pending and lock is not taken.
- Response:
  - `m<head>_recv = s_recv` when the FIFO is non-empty. `m<head>_error/rdata` come from `s`. The non-head master gets recv=0, error=0, rdata=0.
  - `s_ack = m<head>_ack`.
  - Pop on `s_recv && s_ack`.
- Stray response (`s_recv` with FIFO empty): `s_ack=1` (drain), no master sees recv, and `arb_error` is set. `arb_error` is cleared only by reset.
- A push and a pop in the same cycle are both performed, and the count is unchanged.

## Timing
- Reset values:
  - `lock_valid=0`, `lock_id=0`, `last_id=1` (master 0 wins the first tie), FIFO empty, `arb_error=0`.
  - All outputs 0, except `s_ack=1` while the FIFO is empty and `s_recv=1`.
- Request path latency is 0 cycles (m→s and s_gnt→m_gnt are combinational).
- Response path latency is 0 cycles. Responses return strictly in grant order.
- Maximum throughput is one grant per cycle while the FIFO is not full.
- Reset mid-transaction: lock and FIFO are discarded. Any later `s_recv` for a pre-reset transaction is treated as stray.
- A master that drops req before gnt violates the protocol. Behaviour is not required, except that the lock is held until `s_gnt` or reset.

## Test plan
- Single master: m0 load at 0x100, `s_gnt` in the same cycle → `m0_gnt=1` in that cycle. Then `s_recv` with rdata=0xDEADBEEF → `m0_recv=1`, `m0_rdata=0xDEADBEEF`, `m1_recv=0`.
- Tie and round-robin: both request continuously with `s_gnt=1` and immediate responses → grants go m0, m1, m0, m1. `s_addr` alternates between m0_addr and m1_addr.
- Lock: m1 is presented and `s_gnt=0` for 3 cycles while m0 also requests → `s_addr=m1_addr` throughout. m1 is granted on cycle 4, then m0 on cycle 5.
- FIFO full (`OUTSTANDING=2`): two grants with no response → `s_req=0` on the third request. An `s_recv && m_ack` in that cycle still blocks the grant; the grant occurs the next cycle.
- Out-of-order owners: grant m1 then m0, responses 0x11 then 0x22 → `m1_rdata=0x11` first, then `m0_rdata=0x22`. `m1_ack=0` stalls `s_ack` until it is raised.
- Stray response and reset: `s_recv=1` with the FIFO empty → `s_ack=1`, `arb_error=1` stays set, no master recv. Assert `g_resetn=0` with 1 transaction outstanding → FIFO empty, `arb_error=0`, `last_id=1`.
